// File: rtl/iob_stream_mux.sv
// Registered N-to-1 stream multiplexer with valid/ready handshakes.
// A granted channel stays locked until its last beat is accepted; grants come from sel_i or round-robin.
module iob_stream_mux #(
  parameter int DATA_W = 21,
  parameter int N      = 4,
  parameter int SEL_W  = ($clog2(N) > 0 ? $clog2(N) : 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cke_i,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [N-1:0]        in_valid_i,
  input  logic [N*DATA_W-1:0] in_data_i,
  input  logic [N-1:0]        in_last_i,
  output logic [N-1:0]        in_ready_o,
  output logic                out_valid_o,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_last_o,
  output logic [SEL_W-1:0]    out_sel_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  // state  | meaning
  // IDLE   | arbitration cycle, no channel accepted
  // LOCKED | grant_q owns the output until its last beat is accepted
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;

  logic                rr_found;
  logic [SEL_W-1:0]    rr_pick;
  logic                fix_ok;
  logic                grant_rdy;
  logic                accept;

  // Round-robin search starts just after the channel that last finished a packet.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 1; k <= N; k++) begin
      if (!rr_found && in_valid_i[SEL_W'((int'(ptr_q) + k) % N)]) begin
        rr_found = 1'b1;
        rr_pick  = SEL_W'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign fix_ok    = (int'(sel_i) < N) && in_valid_i[sel_i];
  assign grant_rdy = out_ready_i | ~out_valid_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    in_ready_o  = '0;
    accept      = 1'b0;

    if (cke_i) begin
      if (out_valid_q && out_ready_i) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!mode_i) begin
            if (fix_ok) begin
              grant_d = sel_i;
              state_d = ST_LOCKED;
            end
          end else if (rr_found) begin
            grant_d = rr_pick;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          in_ready_o[grant_q] = grant_rdy;
          accept              = in_valid_i[grant_q] & grant_rdy;
          if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i[int'(grant_q)*DATA_W +: DATA_W];
            out_last_d  = in_last_i[grant_q];
            out_sel_d   = grant_q;
            if (in_last_i[grant_q]) begin
              state_d = ST_IDLE;
              ptr_d   = grant_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      ptr_q       <= SEL_W'(N-1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_sel_o   = out_sel_q;
  assign busy_o      = (state_q == ST_LOCKED);

endmodule
